// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// The execute-stage decoder also uses the op encodings.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } muldiv_state_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and output word select. Multiplies negate the full
// 64-bit product; divides negate only the selected quotient or remainder.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic [2:0]         op_i,
    input  logic               neg_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [WIDTH-1:0]   word_o
);

    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] fixed;

    always_comb begin
        if (is_div_op(op_i)) begin
            mag = {{WIDTH{1'b0}}, (op_i[1] ? rem_i : acc_i[WIDTH-1:0])};
        end else begin
            mag = acc_i;
        end
        fixed = neg_i ? ('0 - mag) : mag;
        if (is_div_op(op_i) || (op_i == OP_MUL)) begin
            word_o = fixed[WIDTH-1:0];
        end else begin
            word_o = fixed[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in FINISH.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t      state_q;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic [WIDTH-1:0]   fix_word;

    logic               s1_signed, s2_signed, s1_neg, s2_neg;
    logic               div_zero, div_ovf, start_neg;
    logic [WIDTH-1:0]   mag1, mag2;

    always_comb begin
        s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        s1_neg    = s1_signed & rs1[WIDTH-1];
        s2_neg    = s2_signed & rs2[WIDTH-1];
        mag1      = s1_neg ? ('0 - rs1) : rs1;
        mag2      = s2_neg ? ('0 - rs2) : rs2;
        div_zero  = is_div_op(op) && (rs2 == '0);
        div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
        start_neg = (op == OP_REM) ? s1_neg : (s1_neg ^ s2_neg);
    end

    // Multiply: acc = {partial high, remaining multiplier bits}.
    // Divide: acc low = dividend shifting out MSB-first, quotient shifting in.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        acc_d     = acc_q;
        rem_d     = rem_q;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        div_ge    = 1'b0;
        if (is_div_op(op_q)) begin
            div_shift = {rem_q, acc_q[WIDTH-1]};
            div_ge    = div_shift >= {1'b0, opa_q};
            div_diff  = div_shift[WIDTH-1:0] - opa_q;
            rem_d     = div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc_d     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
            acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op_i   (op_q),
        .neg_i  (neg_q),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .word_o (fix_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opa_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        if (div_zero) begin
                            neg_q   <= 1'b0;
                            acc_q   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            rem_q   <= rs1;
                            state_q <= FINISH;
                        end else if (div_ovf) begin
                            neg_q   <= 1'b0;
                            acc_q   <= {{WIDTH{1'b0}}, MIN_NEG};
                            rem_q   <= '0;
                            state_q <= FINISH;
                        end else begin
                            neg_q   <= start_neg;
                            acc_q   <= {{WIDTH{1'b0}}, (is_div_op(op) ? mag1 : mag2)};
                            opa_q   <= is_div_op(op) ? mag2 : mag1;
                            rem_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    result_q <= fix_word;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
